// File: rtl/music_pkg.sv
// Shared encodings for the music player controller: repeat modes and FSM states.
package music_pkg;

  localparam logic [1:0] REPEAT_NONE = 2'd0;
  localparam logic [1:0] REPEAT_ONE  = 2'd1;
  localparam logic [1:0] REPEAT_ALL  = 2'd2;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_PLAYING = 2'd1,
    ST_SWITCH  = 2'd2
  } state_e;

  // NONE -> ONE -> ALL -> NONE; the unused code 3 also falls back to NONE.
  function automatic logic [1:0] next_repeat(input logic [1:0] m);
    case (m)
      REPEAT_NONE: next_repeat = REPEAT_ONE;
      REPEAT_ONE:  next_repeat = REPEAT_ALL;
      default:     next_repeat = REPEAT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/song_index_counter.sv
// Modulo-NUM_SONGS up/down counter; load_zero wins over inc, inc over dec.
module song_index_counter #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = $clog2(NUM_SONGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic              load_zero,
  output logic [SONG_W-1:0] index
);

  localparam logic [SONG_W-1:0] LAST = SONG_W'(NUM_SONGS - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         index <= '0;
    else if (load_zero) index <= '0;
    else if (inc)       index <= (index == LAST) ? '0 : index + 1'b1;
    else if (dec)       index <= (index == '0) ? LAST : index - 1'b1;
  end

endmodule

// File: rtl/music_player_ctrl.sv
// Play/pause, song selection and repeat-mode controller; issues a multi-cycle
// player_reset pulse to song_reader/note_player whenever the song changes or restarts.
module music_player_ctrl
  import music_pkg::*;
#(
  parameter int NUM_SONGS    = 4,
  parameter int SONG_W       = $clog2(NUM_SONGS),
  parameter int RESET_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              mode_button,
  input  logic              song_done,
  output logic              play,
  output logic [SONG_W-1:0] current_song,
  output logic              player_reset,
  output logic [1:0]        repeat_mode
);

  localparam logic [3:0]        CNT_INIT = 4'(RESET_CYCLES - 1);
  localparam logic [SONG_W-1:0] LAST     = SONG_W'(NUM_SONGS - 1);

  state_e     state, state_nxt;
  logic       resume, resume_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       inc, dec, load_zero;

  song_index_counter #(.NUM_SONGS(NUM_SONGS), .SONG_W(SONG_W)) u_idx (
    .clk       (clk),
    .reset     (reset),
    .inc       (inc),
    .dec       (dec),
    .load_zero (load_zero),
    .index     (current_song)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_PAUSED;
      resume       <= 1'b0;
      cnt          <= '0;
      play         <= 1'b0;
      player_reset <= 1'b0;
      repeat_mode  <= REPEAT_NONE;
    end else begin
      state        <= state_nxt;
      resume       <= resume_nxt;
      cnt          <= cnt_nxt;
      play         <= (state_nxt == ST_PLAYING);
      player_reset <= (state_nxt == ST_SWITCH);
      if (mode_button) repeat_mode <= next_repeat(repeat_mode);
    end
  end

  // Only the highest-priority event acts: next > prev > song_done > play.
  always_comb begin
    state_nxt  = state;
    resume_nxt = resume;
    cnt_nxt    = cnt;
    inc        = 1'b0;
    dec        = 1'b0;
    load_zero  = 1'b0;
    case (state)
      ST_PAUSED, ST_PLAYING: begin
        if (next_button) begin
          inc        = 1'b1;
          resume_nxt = (state == ST_PLAYING);
          state_nxt  = ST_SWITCH;
          cnt_nxt    = CNT_INIT;
        end else if (prev_button) begin
          dec        = 1'b1;
          resume_nxt = (state == ST_PLAYING);
          state_nxt  = ST_SWITCH;
          cnt_nxt    = CNT_INIT;
        end else if (song_done && state == ST_PLAYING) begin
          state_nxt  = ST_SWITCH;
          cnt_nxt    = CNT_INIT;
          resume_nxt = 1'b1;
          case (repeat_mode)
            REPEAT_ONE: ;
            REPEAT_ALL: inc = 1'b1;
            default: begin
              if (current_song == LAST) begin
                load_zero  = 1'b1;
                resume_nxt = 1'b0;
              end else begin
                inc = 1'b1;
              end
            end
          endcase
        end else if (play_button) begin
          state_nxt = (state == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
        end
      end
      ST_SWITCH: begin
        if (cnt == '0) state_nxt = resume ? ST_PLAYING : ST_PAUSED;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = ST_PAUSED;
    endcase
  end

endmodule

// File: tb/tb_music_player_ctrl.sv
// Directed bench for music_player_ctrl (4 songs) plus a 5-song wrap sweep.
module tb_music_player_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_button, next_button, prev_button, mode_button, song_done;
  logic       play, player_reset;
  logic [1:0] current_song;
  logic [1:0] repeat_mode;

  logic       n5, zero5;
  logic       play5, preset5;
  logic [2:0] song5;
  logic [1:0] mode5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  music_player_ctrl #(.NUM_SONGS(4), .RESET_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .play_button(play_button), .next_button(next_button), .prev_button(prev_button),
    .mode_button(mode_button), .song_done(song_done),
    .play(play), .current_song(current_song), .player_reset(player_reset),
    .repeat_mode(repeat_mode)
  );

  music_player_ctrl #(.NUM_SONGS(5), .RESET_CYCLES(2)) dut5 (
    .clk(clk), .reset(reset),
    .play_button(zero5), .next_button(n5), .prev_button(zero5),
    .mode_button(zero5), .song_done(zero5),
    .play(play5), .current_song(song5), .player_reset(preset5),
    .repeat_mode(mode5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Inputs are applied just after a negedge and cleared after the next one,
  // so on return the first registered response is visible.
  task automatic pulse(input logic n, input logic p, input logic pl,
                       input logic d, input logic m);
    next_button = n; prev_button = p; play_button = pl; song_done = d; mode_button = m;
    @(negedge clk);
    next_button = 0; prev_button = 0; play_button = 0; song_done = 0; mode_button = 0;
  endtask

  // Two-cycle player_reset window following an accepted song change.
  task automatic sw_check(input string tag, input logic [1:0] song, input logic fin_play);
    chk({tag, "_song"}, 32'(current_song), 32'(song));
    chk({tag, "_rst1"}, 32'(player_reset), 1);
    chk({tag, "_play1"}, 32'(play), 0);
    step();
    chk({tag, "_rst2"}, 32'(player_reset), 1);
    chk({tag, "_play2"}, 32'(play), 0);
    step();
    chk({tag, "_rst_end"}, 32'(player_reset), 0);
    chk({tag, "_play_end"}, 32'(play), 32'(fin_play));
    chk({tag, "_song_end"}, 32'(current_song), 32'(song));
  endtask

  initial begin
    reset = 0; zero5 = 0; n5 = 0;
    play_button = 0; next_button = 0; prev_button = 0; mode_button = 0; song_done = 0;
    step(); step();
    chk("rst_play", 32'(play), 0);
    chk("rst_song", 32'(current_song), 0);
    chk("rst_preset", 32'(player_reset), 0);
    chk("rst_mode", 32'(repeat_mode), 0);
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_preset", 32'(player_reset), 0);
    end

    pulse(0, 0, 1, 0, 0);
    chk("play_on", 32'(play), 1);
    chk("play_on_song", 32'(current_song), 0);
    chk("play_on_preset", 32'(player_reset), 0);

    // Songs 1,2,3 then wrap 3 -> 0 while playing.
    for (int i = 0; i < 4; i++) begin
      pulse(1, 0, 0, 0, 0);
      sw_check("next_play", 2'((i + 1) % 4), 1);
    end

    pulse(0, 0, 1, 0, 0);
    chk("pause", 32'(play), 0);
    pulse(0, 1, 0, 0, 0);
    sw_check("prev_wrap", 2'd3, 0);

    pulse(0, 0, 1, 0, 0);
    chk("play_s3", 32'(play), 1);
    pulse(0, 0, 0, 1, 0);
    sw_check("done_none_last", 2'd0, 0);
    chk("mode_none", 32'(repeat_mode), 0);

    pulse(0, 0, 0, 0, 1);
    chk("mode_one", 32'(repeat_mode), 1);
    pulse(1, 0, 0, 0, 0);
    sw_check("next_paused1", 2'd1, 0);
    pulse(1, 0, 0, 0, 0);
    sw_check("next_paused2", 2'd2, 0);
    pulse(0, 0, 1, 0, 0);
    chk("play_s2", 32'(play), 1);
    pulse(0, 0, 0, 1, 0);
    sw_check("done_one", 2'd2, 1);

    pulse(0, 1, 0, 0, 0);
    sw_check("prev_play", 2'd1, 1);
    pulse(1, 0, 1, 0, 1);
    chk("combo_mode", 32'(repeat_mode), 2);
    sw_check("combo", 2'd2, 1);

    // Events other than mode are ignored mid-SWITCH.
    pulse(1, 0, 0, 0, 0);
    chk("sw_enter_song", 32'(current_song), 3);
    pulse(0, 1, 1, 1, 1);
    chk("sw_ign_song", 32'(current_song), 3);
    chk("sw_ign_preset", 32'(player_reset), 1);
    chk("sw_mode_wrap", 32'(repeat_mode), 0);
    step();
    chk("sw_ign_end_preset", 32'(player_reset), 0);
    chk("sw_ign_end_play", 32'(play), 1);
    chk("sw_ign_end_song", 32'(current_song), 3);

    pulse(0, 0, 0, 0, 1);
    pulse(0, 0, 0, 0, 1);
    chk("mode_all", 32'(repeat_mode), 2);
    pulse(0, 0, 0, 1, 0);
    sw_check("done_all", 2'd0, 1);

    // Asynchronous reset in the middle of the pulse.
    pulse(1, 0, 0, 0, 0);
    chk("mid_sw_preset", 32'(player_reset), 1);
    chk("mid_sw_song", 32'(current_song), 1);
    #1 reset = 0;
    #1;
    chk("async_play", 32'(play), 0);
    chk("async_song", 32'(current_song), 0);
    chk("async_preset", 32'(player_reset), 0);
    chk("async_mode", 32'(repeat_mode), 0);
    step();
    reset = 1;
    step();
    chk("post_rst_preset", 32'(player_reset), 0);
    chk("post_rst_play", 32'(play), 0);

    // Five songs: index must wrap 4 -> 0 and never exceed 4.
    for (int i = 0; i < 20; i++) begin
      n5 = 1;
      step();
      n5 = 0;
      chk("sweep5_song", 32'(song5), 32'((i + 1) % 5));
      step();
      step();
      chk("sweep5_range", 32'(song5 <= 3'd4), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/music_player_ctrl.md
Name: music_player_ctrl

Overview:
- Parametrised successor to the fixed two-song play/next controller inside music_player.
- Tracks the current song among NUM_SONGS and the play/pause state, and applies a repeat mode.
- Adds previous-song selection and automatic advance on song end.
- Emits a multi-cycle reset pulse to the song reader and note player whenever the song changes or restarts. Sits between the debounced button pulses and song_reader/note_player.

Parameters:
- NUM_SONGS, 4, number of songs; legal range 2..256.
- SONG_W, $clog2(NUM_SONGS), width of the song index.
- RESET_CYCLES, 2, length of the player_reset pulse in cycles; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- play_button  input  1  one-cycle pulse; toggles play/pause.
- next_button  input  1  one-cycle pulse; advance to the next song.
- prev_button  input  1  one-cycle pulse; go to the previous song.
- mode_button  input  1  one-cycle pulse; cycle the repeat mode.
- song_done  input  1  one-cycle pulse from song_reader at the end of a song.
- play  output  1  high while playing; gates song_reader/note_player.
- current_song  output  SONG_W  index of the selected song.
- player_reset  output  1  high for RESET_CYCLES cycles on a song change or restart.
- repeat_mode  output  2  0 = NONE, 1 = ONE, 2 = ALL; 3 is never produced.

Behaviour:
- Reset (reset==0, asynchronous): state PAUSED, play=0, current_song=0, player_reset=0, repeat_mode=0, resume flag=0, reset counter=0.
- All outputs are registered. The first response is visible one cycle after the input pulse.
- States:
  - PAUSED: play=0.
  - PLAYING: play=1.
  - SWITCH: player_reset=1, play=0, counting down RESET_CYCLES.
- Per-cycle event priority: next > prev > song_done > play_button. Only the highest-priority event acts; lower ones that cycle are dropped.
- mode_button is independent of the state events. It acts in any state, in the same cycle as any other event. Sequence 0→1→2→0.
- next_button in PAUSED or PLAYING:
  - current_song <= (current_song==NUM_SONGS-1) ? 0 : current_song+1.
  - resume <= (state==PLAYING).
  - Enter SWITCH.
- prev_button: as next_button, with current_song <= (current_song==0) ? NUM_SONGS-1 : current_song-1.
- song_done in PLAYING, by repeat_mode:
  - ONE: song unchanged; resume=1; enter SWITCH.
  - ALL: advance with wrap; resume=1; enter SWITCH.
  - NONE, not on the last song: advance; resume=1; enter SWITCH.
  - NONE, on the last song: current_song<=0; resume=0; enter SWITCH, ending in PAUSED.
- song_done in PAUSED or SWITCH: ignored.
- play_button: PAUSED→PLAYING, PLAYING→PAUSED. No player_reset; playback position is kept.
- SWITCH:
  - player_reset=1 for exactly RESET_CYCLES consecutive cycles.
  - Then go to PLAYING if resume==1, else PAUSED.
  - next, prev, play and song_done are ignored during SWITCH. mode_button is still honoured.
- current_song changes in the same cycle player_reset first rises, so the reader restarts on the new song.
- Reset asserted mid-SWITCH aborts the pulse; player_reset drops to 0 immediately (asynchronous).
- NUM_SONGS not a power of two: current_song never exceeds NUM_SONGS-1 under any button sequence.

Decomposition:
- Shared package music_pkg holds:
  - repeat-mode encodings REPEAT_NONE/ONE/ALL (2-bit);
  - the state encoding typedef for PAUSED/PLAYING/SWITCH.
- One sub-module, song_index_counter: a modulo-NUM_SONGS up/down counter with wrap. Inputs inc, dec and load_zero; output index.
- The FSM, resume flag and reset-pulse counter stay in music_player_ctrl.

Test Plan:
- Release reset, wait 5 cycles, pulse play → play=1 after 1 cycle, current_song=0, player_reset never asserted.
- NUM_SONGS=4, current_song=3, PLAYING, pulse next → current_song=0, player_reset high exactly 2 cycles, then play=1.
- PAUSED at song 0, pulse prev → current_song=3, player_reset high 2 cycles, play stays 0 throughout.
- repeat_mode=NONE, song 3 PLAYING, pulse song_done → current_song=0, 2-cycle reset, final play=0.
- repeat_mode=ONE (mode pulsed once), song 2 PLAYING, song_done → current_song stays 2, 2-cycle reset, play=1.
- Same-cycle next+play+mode at song 1 PLAYING → current_song=2, repeat_mode increments, play resumes 1. Then pull reset low mid-SWITCH → all outputs 0 immediately. NUM_SONGS=5 sweep of 20 next pulses never shows index >4.
